multibit_mcp_tx_fifo: RTL and testbench
=======================================

# multibit_mcp_tx_fifo

Single-clock first-word-fall-through FIFO that sits directly upstream of the multi-bit MCP synchronizer on its transmit (a-domain) side. The MCP synchronizer accepts only one word per full request/acknowledge round trip, which takes several cycles. This block absorbs producer bursts during that time and presents them one at a time on a valid/ready interface. Its master port connects straight to the synchronizer's avalid/adata/aready.

## Interface
- DATA_WIDTH, 32, payload width; must match the downstream synchronizer
- DEPTH, 8, number of entries; power of two, ≥ 2
- AFULL_THRESH, DEPTH-2, level at or above which almost_full asserts (level feature only)

- clk  input  1  transmit-domain clock; all logic on posedge
- reset_n  input  1  reset, synchronous and active-low
- s_valid  input  1  producer has a word
- s_data  input  DATA_WIDTH  producer word
- s_ready  output  1  FIFO can accept a word
- m_valid  output  1  head word available (to synchronizer avalid)
- m_data  output  DATA_WIDTH  head word (to synchronizer adata)
- m_ready  input  1  consumer accepts (from synchronizer aready)
- level  output  $clog2(DEPTH+1)  current occupancy (only with MCP_TX_FIFO_LEVEL_EN)
- almost_full  output  1  level ≥ AFULL_THRESH (only with MCP_TX_FIFO_LEVEL_EN)

## Operation
- Push = s_valid & s_ready. Pop = m_valid & m_ready. Both are evaluated on the same edge.
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = addresses equal and MSBs differ.
- Occupancy counter:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- s_ready = !full and m_valid = !empty. Both are registered flags computed from next-state pointers.
- m_data = mem[rd_ptr] (asynchronous read). It is stable while m_valid=1 and no pop occurs. Data under m_data is undefined when m_valid=0.
- Words leave in strict arrival order. No word is dropped or duplicated.
- Producer must hold s_valid/s_data until accepted. The FIFO holds m_valid/m_data until popped; m_valid never retracts without a pop.
- Full: s_ready=0, so no push. A pop on the same cycle frees a slot, and s_ready=1 on the next cycle (no same-cycle pass-through).
- Empty: m_valid=0, so no pop. A push makes m_valid=1 on the next cycle (no bypass).
- Reset mid-operation: all contents are discarded. Pointers and count go to 0. Any word in flight on either port is lost. Storage RAM is not cleared.

## Timing
- Reset values (while reset_n=0 and the first cycle after release): s_ready=0, m_valid=0, level=0, almost_full=0.
- s_ready rises in the first cycle after reset_n goes high.
- Latency: a word pushed at edge N is visible with m_valid=1 after edge N (cycle N+1) when the FIFO was empty.
- Sustained throughput is 1 word/cycle when the consumer is always ready. When driving the MCP synchronizer, the rate is bounded by its round trip.
- level and almost_full update on the same edge as the pointers. They are registered and glitch-free.

## Configuration
- MCP_TX_FIFO_LEVEL_EN defined:
  - level and almost_full ports exist.
  - almost_full is a registered compare against AFULL_THRESH.
- MCP_TX_FIFO_LEVEL_EN undefined:
  - Both ports are absent.
  - The occupancy counter is still used internally only if needed for full/empty. Pointer-based flags are preferred, so no count register remains.
- Core FIFO behaviour is identical in both builds.

## Structure
- Package multibit_mcp_pkg:
  - function for address width ($clog2 wrapper with minimum 1).
  - localparam-style default depth constant.
  - typedef for pointer and level types derived from DEPTH.
- Sub-module multibit_mcp_fifo_ram:
  - DEPTH × DATA_WIDTH array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset.
- Top block holds pointers, flags, optional level logic and port glue.

## Test plan
- Reset then idle:
  - Hold reset_n=0 for 3 cycles, release → s_ready=0 in the release cycle, then s_ready=1, m_valid=0, level=0.
- Single word:
  - Push 0xDEADBEEF at edge N, m_ready=1 → m_valid=1 and m_data=0xDEADBEEF in cycle N+1.
  - Popped at edge N+1, m_valid=0 after.
- Fill to full:
  - DEPTH=8, m_ready=0, push 0x0..0x7 → s_ready=0 after the 8th push, level=8, almost_full=1 from level 6.
  - A 9th s_valid is not accepted.
- Drain from full with simultaneous activity:
  - At full, pulse m_ready for one cycle with s_valid=1 → pop 0x0, no push that cycle.
  - s_ready=1 next cycle; next push 0x8 lands; output order is 0x1..0x8.
- Wrap-around / MCP pacing:
  - Stream 40 incrementing words, m_ready asserted 1 cycle in every 5 (mimicking the synchronizer round trip).
  - All 40 arrive in order, with no loss or duplicates, and m_data is stable while m_valid=1 and m_ready=0.
- Reset mid-operation:
  - With 5 words held, drive reset_n=0 for 1 cycle → m_valid=0 and level=0 next cycle.
  - A subsequent push of 0xA5 is the first word out.

Source files
------------

// File: rtl/multibit_mcp_pkg.sv
// Shared sizing helpers and default types for the MCP transmit-side FIFO.
package multibit_mcp_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;

  // Address width never drops below one bit, so a 2-entry FIFO still has a real address.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [addr_width(DEFAULT_DEPTH):0]   ptr_t;
  typedef logic [$clog2(DEFAULT_DEPTH+1)-1:0]   level_t;

endpackage

// File: rtl/multibit_mcp_fifo_ram.sv
// Storage for the MCP transmit FIFO: synchronous write, asynchronous read, no reset.
module multibit_mcp_fifo_ram
  import multibit_mcp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/multibit_mcp_tx_fifo.sv
// First-word-fall-through FIFO feeding the multi-bit MCP synchronizer (a-domain side).
// Define MCP_TX_FIFO_LEVEL_EN to expose the level and almost_full ports.
module multibit_mcp_tx_fifo
  import multibit_mcp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  input  logic                         m_ready
`ifdef MCP_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
`endif
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic          s_ready_q, m_valid_q;
  logic          push, pop;
  logic          empty_nxt, full_nxt;

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid_q & m_ready;

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                 (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  // Flags are registered from next-state pointers, so neither path bypasses storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      s_ready_q <= !full_nxt;
      m_valid_q <= !empty_nxt;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;

  multibit_mcp_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_data)
  );

`ifdef MCP_TX_FIFO_LEVEL_EN
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

  logic [LW-1:0] level_q, level_nxt;
  logic          almost_full_q;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_nxt;
      almost_full_q <= (level_nxt >= AFULL_L);
    end
  end

  assign level       = level_q;
  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_multibit_mcp_tx_fifo.sv
// Directed self-checking bench for multibit_mcp_tx_fifo (DEPTH=8, DATA_WIDTH=32).
module tb_multibit_mcp_tx_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef MCP_TX_FIFO_LEVEL_EN
  logic [3:0]    level;
  logic          almost_full;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  multibit_mcp_tx_fifo #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (DEPTH - 2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready)
`ifdef MCP_TX_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus changes and sampling both happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) tick();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    reset_n = 1'b1;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL release_cycle_s_ready got=%b exp=0", s_ready); end
    tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL post_reset_m_valid got=%b exp=0", m_valid); end
`ifdef MCP_TX_FIFO_LEVEL_EN
    total++; if (level !== 4'd0) begin bad++; $display("FAIL post_reset_level got=%0d exp=0", level); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL post_reset_afull got=%b exp=0", almost_full); end
`endif
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 32'hDEADBEEF; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid got=%b exp=1", m_valid); end
    total++; if (m_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_m_data got=%h exp=deadbeef", m_data); end
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b exp=1", i, s_ready); end
      s_valid = 1'b1; s_data = DW'(i);
      tick();
`ifdef MCP_TX_FIFO_LEVEL_EN
      total++; if (level !== 4'(i + 1)) begin bad++; $display("FAIL fill_level_%0d got=%0d exp=%0d", i, level, i + 1); end
      total++; if (almost_full !== ((i + 1) >= 6)) begin bad++; $display("FAIL fill_afull_%0d got=%b exp=%b", i, almost_full, (i + 1) >= 6); end
`endif
    end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
    s_data = 32'h8;
    tick();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ninth_s_ready got=%b exp=0", s_ready); end
    total++; if (m_data !== 32'h0) begin bad++; $display("FAIL full_head got=%h exp=0", m_data); end
`ifdef MCP_TX_FIFO_LEVEL_EN
    total++; if (level !== 4'd8) begin bad++; $display("FAIL ninth_level got=%0d exp=8", level); end
`endif
  endtask

  task automatic test_drain_full();
    // s_valid=1, s_data=8 still held from the rejected ninth word
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pop_at_full_s_ready got=%b exp=1", s_ready); end
    total++; if (m_data !== 32'h1) begin bad++; $display("FAIL pop_at_full_head got=%h exp=1", m_data); end
`ifdef MCP_TX_FIFO_LEVEL_EN
    total++; if (level !== 4'd7) begin bad++; $display("FAIL pop_at_full_level got=%0d exp=7", level); end
`endif
    tick();
    s_valid = 1'b0;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL refill_s_ready got=%b exp=0", s_ready); end
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== DW'(k)) begin
        bad++; $display("FAIL drain_order_%0d got=%b/%h exp=1/%h", k, m_valid, m_data, k);
      end
      tick();
    end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_mcp_pacing();
    int unsigned sent = 0;
    int unsigned rcvd = 0;
    logic          hold_chk = 1'b0;
    logic [DW-1:0] held = '0;
    logic          did_push, did_pop;
    s_valid = 1'b1; s_data = 32'd100;
    for (int cyc = 0; cyc < 2000 && rcvd < 40; cyc++) begin
      m_ready = ((cyc % 5) == 4);
      if (hold_chk) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          bad++; $display("FAIL pacing_stable_c%0d got=%b/%h exp=1/%h", cyc, m_valid, m_data, held);
        end
      end
      did_push = s_valid && s_ready;
      did_pop  = m_valid && m_ready;
      if (did_pop) begin
        total++;
        if (m_data !== DW'(100 + rcvd)) begin
          bad++; $display("FAIL pacing_order_%0d got=%h exp=%h", rcvd, m_data, DW'(100 + rcvd));
        end
        rcvd++;
      end
      hold_chk = m_valid && !m_ready;
      held     = m_data;
      tick();
      if (did_push) begin
        sent++;
        if (sent < 40) s_data = DW'(100 + sent);
        else           s_valid = 1'b0;
      end
    end
    m_ready = 1'b0;
    total++; if (rcvd != 40) begin bad++; $display("FAIL pacing_count got=%0d exp=40", rcvd); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL pacing_leftover got=%b exp=0", m_valid); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = DW'(32'h50 + i);
      tick();
    end
    s_valid = 1'b0;
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_loaded got=%b exp=1", m_valid); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_m_valid got=%b exp=0", m_valid); end
`ifdef MCP_TX_FIFO_LEVEL_EN
    total++; if (level !== 4'd0) begin bad++; $display("FAIL mid_reset_level got=%0d exp=0", level); end
`endif
    tick();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_s_ready got=%b exp=1", s_ready); end
    s_valid = 1'b1; s_data = 32'hA5;
    tick();
    s_valid = 1'b0;
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'hA5) begin
      bad++; $display("FAIL mid_reset_first_word got=%b/%h exp=1/a5", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_drain got=%b exp=0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain_full();
    test_mcp_pacing();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
